tcam_ctrl: RTL and testbench

TCAM_CTRL -- requirements
Module: tcam_ctrl

---
 rtl/tcam_ctrl.sv | 150 +++++++++++++++
 tb/tb_tcam_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_ctrl.sv
// TCAM command controller: searches, writes and invalidates a 16-entry external TCAM,
// keeping a per-entry valid mask so stale entries never report a hit.
module tcam_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_key,
    input  logic [15:0] cmd_mask,
    output logic [3:0]  cam_wraddr,
    output logic [15:0] cam_value,
    output logic [15:0] cam_value2,
    output logic        cam_wr,
    input  logic [15:0] cam_match,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_hit,
    output logic [3:0]  rsp_index,
    output logic        rsp_multi,
    output logic [4:0]  rsp_count
);

    localparam logic [1:0] OP_SEARCH  = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_INV     = 2'b10;
    localparam logic [1:0] OP_INV_ALL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WRITE  = 2'b01,
        S_SEARCH = 2'b10,
        S_RESP   = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic [15:0] r_entry_valid;
    logic [3:0]  r_cam_wraddr;
    logic [15:0] r_cam_value;
    logic [15:0] r_cam_value2;
    logic        r_rsp_hit;
    logic [3:0]  r_rsp_index;
    logic        r_rsp_multi;
    logic [4:0]  r_rsp_count;
    logic [15:0] w_hits;
    logic [3:0]  w_low;
    logic [4:0]  w_count;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // cmd_valid/rsp_ready may change freely while the partner's signal is low.
    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && cmd_op == OP_SEARCH) begin
                    w_next = S_SEARCH;
                end else if (w_accept && cmd_op == OP_WRITE) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE:  w_next = S_IDLE;
            S_SEARCH: w_next = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Only entries currently marked valid may contribute to a search result.
    assign w_hits = cam_match & r_entry_valid;

    always_comb begin
        w_low   = 4'd0;
        w_count = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_hits[i]) begin
                w_low = 4'(i);
            end
        end
        for (int i = 0; i < 16; i++) begin
            w_count = w_count + 5'(w_hits[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry_valid <= 16'd0;
            r_cam_wraddr  <= 4'd0;
            r_cam_value   <= 16'd0;
            r_cam_value2  <= 16'd0;
            r_rsp_hit     <= 1'b0;
            r_rsp_index   <= 4'd0;
            r_rsp_multi   <= 1'b0;
            r_rsp_count   <= 5'd0;
        end else begin
            if (w_accept && cmd_op == OP_SEARCH) begin
                r_cam_value <= cmd_key;
            end
            if (w_accept && cmd_op == OP_WRITE) begin
                r_cam_wraddr <= cmd_addr;
                r_cam_value  <= cmd_key;
                r_cam_value2 <= cmd_mask;
            end
            if (w_accept && cmd_op == OP_INV) begin
                r_entry_valid[cmd_addr] <= 1'b0;
            end
            if (w_accept && cmd_op == OP_INV_ALL) begin
                r_entry_valid <= 16'd0;
            end
            // The write strobe is visible for the whole WRITE cycle; the entry turns valid as it closes.
            if (r_state == S_WRITE) begin
                r_entry_valid[r_cam_wraddr] <= 1'b1;
            end
            if (r_state == S_SEARCH) begin
                r_rsp_hit   <= |w_hits;
                r_rsp_index <= w_low;
                r_rsp_count <= w_count;
                r_rsp_multi <= (w_count > 5'd1);
            end
        end
    end

    assign cam_wr     = (r_state == S_WRITE);
    assign rsp_valid  = (r_state == S_RESP);
    assign cam_wraddr = r_cam_wraddr;
    assign cam_value  = r_cam_value;
    assign cam_value2 = r_cam_value2;
    assign rsp_hit    = r_rsp_hit;
    assign rsp_index  = r_rsp_index;
    assign rsp_multi  = r_rsp_multi;
    assign rsp_count  = r_rsp_count;

endmodule

// File: tb/tb_tcam_ctrl.sv
// Directed bench for tcam_ctrl: a table of commands with hand-computed results,
// followed by hand-written backpressure and reset-abort sequences.
module tb_tcam_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_key;
    logic [15:0] cmd_mask;
    logic [3:0]  cam_wraddr;
    logic [15:0] cam_value;
    logic [15:0] cam_value2;
    logic        cam_wr;
    logic [15:0] cam_match;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [3:0]  rsp_index;
    logic        rsp_multi;
    logic [4:0]  rsp_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0]  exp_wraddr = 4'd0;
    logic [15:0] exp_value  = 16'd0;
    logic [15:0] exp_value2 = 16'd0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [15:0] key;
        logic [15:0] mask;
        logic [15:0] match;
        logic        exp_hit;
        logic [3:0]  exp_index;
        logic [4:0]  exp_count;
        logic        exp_multi;
    } vec_t;

    vec_t vecs[$];

    tcam_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_key    (cmd_key),
        .cmd_mask   (cmd_mask),
        .cam_wraddr (cam_wraddr),
        .cam_value  (cam_value),
        .cam_value2 (cam_value2),
        .cam_wr     (cam_wr),
        .cam_match  (cam_match),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_hit    (rsp_hit),
        .rsp_index  (rsp_index),
        .rsp_multi  (rsp_multi),
        .rsp_count  (rsp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input logic [1:0] op, input logic [3:0] addr,
                                input logic [15:0] key, input logic [15:0] mask,
                                input logic [15:0] match, input logic hit, input logic [3:0] idx,
                                input logic [4:0] cnt, input logic multi);
        vec_t v;
        v.name = name; v.op = op; v.addr = addr; v.key = key; v.mask = mask; v.match = match;
        v.exp_hit = hit; v.exp_index = idx; v.exp_count = cnt; v.exp_multi = multi;
        return v;
    endfunction

    task automatic check_rsp(input string name, input logic hit, input logic [3:0] idx,
                             input logic [4:0] cnt, input logic multi);
        chk({name, " rsp_hit"},   32'(rsp_hit),   32'(hit));
        chk({name, " rsp_index"}, 32'(rsp_index), 32'(idx));
        chk({name, " rsp_count"}, 32'(rsp_count), 32'(cnt));
        chk({name, " rsp_multi"}, 32'(rsp_multi), 32'(multi));
    endtask

    // Offer a command, then follow it through the expected cycle-by-cycle behaviour.
    task automatic run_cmd(input vec_t v);
        int waited = 0;
        while (!cmd_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk({v.name, " ready_before"}, 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_addr  = v.addr;
        cmd_key   = v.key;
        cmd_mask  = v.mask;
        cam_match = v.match;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_addr  = 4'($urandom_range(0, 15));
        cmd_key   = 16'($urandom_range(0, 65535));
        cmd_mask  = 16'($urandom_range(0, 65535));
        case (v.op)
            2'b00: begin
                exp_value = v.key;
                chk({v.name, " search cam_value"}, 32'(cam_value), 32'(exp_value));
                chk({v.name, " search cam_wr"}, 32'(cam_wr), 32'd0);
                chk({v.name, " search rsp_valid_early"}, 32'(rsp_valid), 32'd0);
                chk({v.name, " search cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
                tick();
                chk({v.name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
                check_rsp(v.name, v.exp_hit, v.exp_index, v.exp_count, v.exp_multi);
                tick();
                chk({v.name, " rsp_valid_done"}, 32'(rsp_valid), 32'd0);
                chk({v.name, " ready_after"}, 32'(cmd_ready), 32'd1);
            end
            2'b01: begin
                exp_wraddr = v.addr;
                exp_value  = v.key;
                exp_value2 = v.mask;
                chk({v.name, " cam_wr"}, 32'(cam_wr), 32'd1);
                chk({v.name, " cam_wraddr"}, 32'(cam_wraddr), 32'(exp_wraddr));
                chk({v.name, " cam_value"}, 32'(cam_value), 32'(exp_value));
                chk({v.name, " cam_value2"}, 32'(cam_value2), 32'(exp_value2));
                chk({v.name, " cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
                tick();
                chk({v.name, " cam_wr_end"}, 32'(cam_wr), 32'd0);
                chk({v.name, " ready_after"}, 32'(cmd_ready), 32'd1);
            end
            default: begin
                chk({v.name, " inv ready"}, 32'(cmd_ready), 32'd1);
                chk({v.name, " inv cam_wr"}, 32'(cam_wr), 32'd0);
                chk({v.name, " inv rsp_valid"}, 32'(rsp_valid), 32'd0);
                chk({v.name, " inv cam_value_hold"}, 32'(cam_value), 32'(exp_value));
                chk({v.name, " inv cam_value2_hold"}, 32'(cam_value2), 32'(exp_value2));
            end
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("reset cmd_ready_low", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        exp_wraddr = 4'd0;
        exp_value  = 16'd0;
        exp_value2 = 16'd0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 4'd0;
        cmd_key   = 16'd0;
        cmd_mask  = 16'd0;
        cam_match = 16'd0;
        rsp_ready = 1'b1;

        vecs.push_back(mk("s_empty",   2'b00, 4'd0, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 4'd0, 5'd0, 1'b0));
        vecs.push_back(mk("w3",        2'b01, 4'd3, 16'h00AB, 16'h0000, 16'h0000, 1'b0, 4'd0, 5'd0, 1'b0));
        vecs.push_back(mk("s_one",     2'b00, 4'd0, 16'h00AB, 16'h0000, 16'h0008, 1'b1, 4'd3, 5'd1, 1'b0));
        vecs.push_back(mk("w2",        2'b01, 4'd2, 16'h1111, 16'h000F, 16'h0000, 1'b0, 4'd0, 5'd0, 1'b0));
        vecs.push_back(mk("w5",        2'b01, 4'd5, 16'h2222, 16'h00F0, 16'h0000, 1'b0, 4'd0, 5'd0, 1'b0));
        vecs.push_back(mk("w9",        2'b01, 4'd9, 16'h3333, 16'hFFFF, 16'h0000, 1'b0, 4'd0, 5'd0, 1'b0));
        vecs.push_back(mk("s_multi",   2'b00, 4'd0, 16'h5555, 16'h0000, 16'h0224, 1'b1, 4'd2, 5'd3, 1'b1));
        vecs.push_back(mk("inv2",      2'b10, 4'd2, 16'hDEAD, 16'hBEEF, 16'h0000, 1'b0, 4'd0, 5'd0, 1'b0));
        vecs.push_back(mk("s_inv2",    2'b00, 4'd0, 16'h5555, 16'h0000, 16'h0224, 1'b1, 4'd5, 5'd2, 1'b1));
        vecs.push_back(mk("s_all3",    2'b00, 4'd0, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 4'd3, 5'd3, 1'b1));
        vecs.push_back(mk("s_stale2",  2'b00, 4'd0, 16'h0001, 16'h0000, 16'h0004, 1'b0, 4'd0, 5'd0, 1'b0));
        vecs.push_back(mk("w5_again",  2'b01, 4'd5, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 4'd0, 5'd0, 1'b0));
        vecs.push_back(mk("s_over5",   2'b00, 4'd0, 16'hABCD, 16'h0000, 16'h0020, 1'b1, 4'd5, 5'd1, 1'b0));
        vecs.push_back(mk("inv_all",   2'b11, 4'd7, 16'h0F0F, 16'hF0F0, 16'h0000, 1'b0, 4'd0, 5'd0, 1'b0));
        vecs.push_back(mk("s_clr1",    2'b00, 4'd0, 16'h5555, 16'h0000, 16'h0224, 1'b0, 4'd0, 5'd0, 1'b0));
        vecs.push_back(mk("s_clr2",    2'b00, 4'd0, 16'h9999, 16'h0000, 16'hFFFF, 1'b0, 4'd0, 5'd0, 1'b0));
        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mk($sformatf("wall%0d", i), 2'b01, 4'(i), 16'(i * 16'h0101), 16'h0000,
                              16'h0000, 1'b0, 4'd0, 5'd0, 1'b0));
        end
        vecs.push_back(mk("s_full",    2'b00, 4'd0, 16'h4242, 16'h0000, 16'hFFFF, 1'b1, 4'd0, 5'd16, 1'b1));
        vecs.push_back(mk("s_top",     2'b00, 4'd0, 16'h4343, 16'h0000, 16'h8000, 1'b1, 4'd15, 5'd1, 1'b0));
        vecs.push_back(mk("inv0",      2'b10, 4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4'd0, 5'd0, 1'b0));
        vecs.push_back(mk("s_low",     2'b00, 4'd0, 16'h4444, 16'h0000, 16'h0003, 1'b1, 4'd1, 5'd1, 1'b0));

        tick();
        tick();
        chk("reset cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset cam_wr", 32'(cam_wr), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset cam_wraddr", 32'(cam_wraddr), 32'd0);
        chk("reset cam_value", 32'(cam_value), 32'd0);
        chk("reset cam_value2", 32'(cam_value2), 32'd0);
        check_rsp("reset", 1'b0, 4'd0, 5'd0, 1'b0);

        foreach (vecs[i]) begin
            run_cmd(vecs[i]);
        end

        // Backpressure: entries 1..15 valid, match 0x00F0 hits 4..7.
        rsp_ready = 1'b0;
        cam_match = 16'h00F0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_key   = 16'h7E7E;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
        check_rsp("bp first", 1'b1, 4'd4, 5'd4, 1'b1);
        cam_match = 16'hFFFF;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_addr  = 4'd0;
        cmd_key   = 16'h1357;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp hold%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp hold%0d cmd_ready", i), 32'(cmd_ready), 32'd0);
            chk($sformatf("bp hold%0d cam_wr", i), 32'(cam_wr), 32'd0);
            check_rsp($sformatf("bp hold%0d", i), 1'b1, 4'd4, 5'd4, 1'b1);
        end
        chk("bp cam_value_hold", 32'(cam_value), 32'h7E7E);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("bp release rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp release cmd_ready", 32'(cmd_ready), 32'd1);
        exp_value = 16'h7E7E;

        // Reset while a write strobe is in flight.
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_addr  = 4'd7;
        cmd_key   = 16'h7777;
        cmd_mask  = 16'h0000;
        tick();
        cmd_valid = 1'b0;
        chk("rstw cam_wr_before", 32'(cam_wr), 32'd1);
        rst = 1'b1;
        tick();
        chk("rstw cam_wr", 32'(cam_wr), 32'd0);
        chk("rstw rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstw cam_wraddr", 32'(cam_wraddr), 32'd0);
        chk("rstw cam_value", 32'(cam_value), 32'd0);
        do_reset();
        chk("rstw cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        chk("rstw cam_wr_after", 32'(cam_wr), 32'd0);
        run_cmd(mk("s_after_rstw", 2'b00, 4'd0, 16'h2468, 16'h0000, 16'hFFFF, 1'b0, 4'd0, 5'd0, 1'b0));

        // Reset while a response is pending.
        run_cmd(mk("w4", 2'b01, 4'd4, 16'h4444, 16'h0000, 16'h0000, 1'b0, 4'd0, 5'd0, 1'b0));
        rsp_ready = 1'b0;
        cam_match = 16'hFFFF;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_key   = 16'h0404;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rstr rsp_valid_before", 32'(rsp_valid), 32'd1);
        check_rsp("rstr before", 1'b1, 4'd4, 5'd1, 1'b0);
        rst = 1'b1;
        tick();
        chk("rstr rsp_valid", 32'(rsp_valid), 32'd0);
        check_rsp("rstr", 1'b0, 4'd0, 5'd0, 1'b0);
        do_reset();
        chk("rstr cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rstr idle%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("rstr idle%0d cam_wr", i), 32'(cam_wr), 32'd0);
        end
        rsp_ready = 1'b1;
        run_cmd(mk("s_after_rstr", 2'b00, 4'd0, 16'h1357, 16'h0000, 16'hFFFF, 1'b0, 4'd0, 5'd0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
